adt7420_poller: RTL and testbench



---
 rtl/adt7420_poller.sv | 207 ++++++++++++++++++++
 tb/tb_adt7420_poller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_poller.sv
// ADT7420 polling sequencer: one config write after enable, then a periodic 2-byte
// temperature read through i2c_master, with bounded retries and sticky error reporting.
module adt7420_poller #(
    parameter logic [6:0]  I2C_ADDR    = 7'h4B,
    parameter logic [7:0]  TEMP_REG    = 8'h00,
    parameter logic [7:0]  CFG_REG     = 8'h03,
    parameter logic [7:0]  CFG_VALUE   = 8'h80,
    parameter logic [23:0] POLL_PERIOD = 24'd10_000_000,
    parameter int unsigned MAX_RETRIES = 2
) (
    input  logic        i_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clr_err,
    output logic [7:0]  o_addr_w_rw,
    output logic [15:0] o_sub_addr,
    output logic        o_sub_len,
    output logic [23:0] o_byte_len,
    output logic [7:0]  o_data_write,
    output logic        o_req_trans,
    input  logic [7:0]  i_data_out,
    input  logic        i_valid_out,
    input  logic        i_req_data_chunk,
    input  logic        i_busy,
    input  logic        i_nack,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        cfg_done,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic        active
);

    localparam logic [23:0] TmrReload  = POLL_PERIOD - 24'd1;
    localparam logic [7:0]  MaxRetries = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StIdle, StCfgReq, StRdReq, StXfer, StDone, StWaitTmr
    } state_e;

    state_e      state_q;
    logic        is_rd_q, req_q, fail_q, ok_q;
    logic [7:0]  addr_q, wdata_q, msb_q, lsb_q, retry_q;
    logic [15:0] sub_q;
    logic [23:0] len_q, timer_q;
    logic [1:0]  cnt_q;
    logic [15:0] temp_q;
    logic        tvalid_q, cfg_done_q, err_q;
    logic [7:0]  err_cnt_q;

    logic        fail_d, xfer_ok;
    logic [1:0]  cnt_d;
    logic [7:0]  msb_d, lsb_d;
    logic        unused_chunk;

    assign unused_chunk = i_req_data_chunk;

    // Fold in the current cycle so a NACK or byte coincident with busy falling still counts.
    always_comb begin
        fail_d = fail_q | i_nack;
        cnt_d  = cnt_q;
        msb_d  = msb_q;
        lsb_d  = lsb_q;
        if (i_valid_out) begin
            if (cnt_q == 2'd0) begin
                msb_d = i_data_out;
                cnt_d = 2'd1;
            end else if (cnt_q == 2'd1) begin
                lsb_d = i_data_out;
                cnt_d = 2'd2;
            end
        end
        xfer_ok = !fail_d && (!is_rd_q || cnt_d == 2'd2);
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            is_rd_q    <= 1'b0;
            req_q      <= 1'b0;
            fail_q     <= 1'b0;
            ok_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            msb_q      <= 8'h00;
            lsb_q      <= 8'h00;
            retry_q    <= 8'h00;
            sub_q      <= 16'h0000;
            len_q      <= 24'h0;
            timer_q    <= 24'h0;
            cnt_q      <= 2'd0;
            temp_q     <= 16'h0000;
            tvalid_q   <= 1'b0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'h00;
        end else begin
            tvalid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        if (cfg_done_q) begin
                            state_q <= StWaitTmr;
                            timer_q <= TmrReload;
                        end else begin
                            state_q <= StCfgReq;
                            is_rd_q <= 1'b0;
                            req_q   <= 1'b1;
                            addr_q  <= {I2C_ADDR, 1'b0};
                            sub_q   <= {8'h00, CFG_REG};
                            len_q   <= 24'd1;
                            wdata_q <= CFG_VALUE;
                        end
                    end
                end
                StCfgReq, StRdReq: begin
                    if (i_busy) begin
                        req_q   <= 1'b0;
                        fail_q  <= 1'b0;
                        cnt_q   <= 2'd0;
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    fail_q <= fail_d;
                    cnt_q  <= cnt_d;
                    msb_q  <= msb_d;
                    lsb_q  <= lsb_d;
                    if (!i_busy) begin
                        state_q <= StDone;
                        ok_q    <= xfer_ok;
                        if (xfer_ok && is_rd_q) begin
                            temp_q   <= {msb_d, lsb_d};
                            tvalid_q <= 1'b1;
                        end
                        if (xfer_ok && !is_rd_q) begin
                            cfg_done_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (ok_q) begin
                        retry_q <= 8'h00;
                        state_q <= StWaitTmr;
                        timer_q <= TmrReload;
                    end else if (retry_q < MaxRetries) begin
                        // Request fields are still held from the failed attempt.
                        retry_q <= retry_q + 8'd1;
                        req_q   <= 1'b1;
                        state_q <= is_rd_q ? StRdReq : StCfgReq;
                    end else begin
                        err_q   <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                        retry_q <= 8'h00;
                        state_q <= StWaitTmr;
                        timer_q <= TmrReload;
                    end
                end
                StWaitTmr: begin
                    if (!enable) begin
                        state_q <= StIdle;
                    end else if (timer_q == 24'h0) begin
                        req_q   <= 1'b1;
                        addr_q  <= {I2C_ADDR, cfg_done_q};
                        if (cfg_done_q) begin
                            state_q <= StRdReq;
                            is_rd_q <= 1'b1;
                            sub_q   <= {8'h00, TEMP_REG};
                            len_q   <= 24'd2;
                            wdata_q <= 8'h00;
                        end else begin
                            state_q <= StCfgReq;
                            is_rd_q <= 1'b0;
                            sub_q   <= {8'h00, CFG_REG};
                            len_q   <= 24'd1;
                            wdata_q <= CFG_VALUE;
                        end
                    end else begin
                        timer_q <= timer_q - 24'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Clearing takes priority over an error raised in the same cycle.
            if (clr_err) begin
                err_q     <= 1'b0;
                err_cnt_q <= 8'h00;
            end
        end
    end

    assign o_addr_w_rw  = addr_q;
    assign o_sub_addr   = sub_q;
    assign o_sub_len    = 1'b0;
    assign o_byte_len   = len_q;
    assign o_data_write = wdata_q;
    assign o_req_trans  = req_q;
    assign temp_data    = temp_q;
    assign temp_valid   = tvalid_q;
    assign cfg_done     = cfg_done_q;
    assign err          = err_q;
    assign err_cnt      = err_cnt_q;
    assign active       = (state_q != StIdle);

endmodule

// File: tb/tb_adt7420_poller.sv
// Bench for adt7420_poller: an i2c_master BFM plays scripted per-attempt outcomes while a
// transaction-level model predicts requests, samples and error counts.
module tb_adt7420_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, clr_err;
    logic [7:0]  addr, dwr, dout, err_cnt;
    logic [15:0] sub, temp;
    logic [23:0] blen;
    logic        sub_len, req, valid, busy, nack, tv, cfg_done, err, active;

    adt7420_poller #(.POLL_PERIOD(24'd100)) dut (
        .i_clk(clk), .reset(reset), .enable(enable), .clr_err(clr_err),
        .o_addr_w_rw(addr), .o_sub_addr(sub), .o_sub_len(sub_len), .o_byte_len(blen),
        .o_data_write(dwr), .o_req_trans(req), .i_data_out(dout), .i_valid_out(valid),
        .i_req_data_chunk(1'b0), .i_busy(busy), .i_nack(nack), .temp_data(temp),
        .temp_valid(tv), .cfg_done(cfg_done), .err(err), .err_cnt(err_cnt), .active(active)
    );

    typedef struct packed {
        logic       nack;
        logic [1:0] nbytes;
        logic [7:0] b0, b1, b2;
    } plan_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] sub;
        logic [23:0] len;
        logic [7:0]  data;
    } req_t;

    plan_t plans[$];
    req_t  reqs[$];
    int    req_stamp[$];
    int    cyc = 0;
    int    ncmp = 0, nfail = 0;
    int    tv_cnt = 0, tv_dbl = 0;
    logic  tv_prev = 1'b0;
    logic [15:0] tv_last = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tv) begin
            tv_cnt  <= tv_cnt + 1;
            tv_last <= temp;
            if (tv_prev) tv_dbl <= tv_dbl + 1;
        end
        tv_prev <= tv;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic plan_t mk(input logic n, input logic [1:0] nb, input logic [7:0] b0,
                                 input logic [7:0] b1, input logic [7:0] b2);
        plan_t p;
        p.nack = n; p.nbytes = nb; p.b0 = b0; p.b1 = b1; p.b2 = b2;
        return p;
    endfunction

    // i2c_master BFM: each accepted request consumes one plan entry.
    initial begin
        plan_t p;
        req_t  r;
        busy = 1'b0; valid = 1'b0; nack = 1'b0; dout = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (req === 1'b1 && !busy && reset === 1'b0) begin
                r.addr = addr; r.sub = sub; r.len = blen; r.data = dwr;
                reqs.push_back(r);
                req_stamp.push_back(cyc);
                p = (plans.size() > 0) ? plans.pop_front() : mk(1'b0, 2'd0, 8'h0, 8'h0, 8'h0);
                repeat (2) @(posedge clk); #1;
                busy = 1'b1;
                repeat (2) @(posedge clk); #1;
                if (!reset) chk("req_low_while_busy", req, 0);
                if (p.nack) begin
                    nack = 1'b1; @(posedge clk); #1; nack = 1'b0;
                end else begin
                    for (int i = 0; i < int'(p.nbytes); i++) begin
                        dout  = (i == 0) ? p.b0 : (i == 1) ? p.b1 : p.b2;
                        valid = 1'b1; @(posedge clk); #1;
                        valid = 1'b0; @(posedge clk); #1;
                    end
                end
                if (!reset) begin
                    chk("hold_addr", addr, r.addr);
                    chk("hold_len", blen, r.len);
                end
                busy = 1'b0;
            end
        end
    end

    task automatic wait_reqs(input int n);
        int k;
        k = 0;
        while (reqs.size() < n && k < 700) begin
            @(posedge clk); #1; k++;
        end
        if (reqs.size() < n) chk("req_timeout", reqs.size(), n);
        repeat (20) @(posedge clk); #1;
    endtask

    initial begin
        int exp_req, exp_tv, exp_errcnt, att, o, k, n;
        logic exp_err, ok;
        logic [15:0] exp_temp;
        plan_t pl;

        reset = 1'b1; enable = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_temp", temp, 0);
        chk("rst_flags", {tv, cfg_done, err, active}, 0);
        chk("rst_errcnt", err_cnt, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Config then first read
        plans.push_back(mk(1'b0, 2'd0, 8'h00, 8'h00, 8'h00));
        plans.push_back(mk(1'b0, 2'd2, 8'h0C, 8'h80, 8'h00));
        enable = 1'b1;
        wait_reqs(2);
        chk("cfg_addr", reqs[0].addr, 8'h96);
        chk("cfg_sub", reqs[0].sub, 16'h0003);
        chk("cfg_len", reqs[0].len, 1);
        chk("cfg_data", reqs[0].data, 8'h80);
        chk("rd_addr", reqs[1].addr, 8'h97);
        chk("rd_sub", reqs[1].sub, 16'h0000);
        chk("rd_len", reqs[1].len, 2);
        chk("sub_len", sub_len, 0);
        n = req_stamp[1] - req_stamp[0];
        chk("poll_gap", (n >= 100 && n <= 130), 1);
        chk("cfg_done", cfg_done, 1);
        chk("temp_25c", temp, 16'h0C80);
        chk("tv_cnt1", tv_cnt, 1);
        chk("tv_last1", tv_last, 16'h0C80);

        // Negative, then zero
        plans.push_back(mk(1'b0, 2'd2, 8'hF3, 8'h80, 8'h00));
        wait_reqs(3);
        chk("temp_neg", temp, 16'hF380);
        chk("tv_cnt2", tv_cnt, 2);
        plans.push_back(mk(1'b0, 2'd2, 8'h00, 8'h00, 8'h00));
        wait_reqs(4);
        chk("temp_zero", temp, 16'h0000);
        chk("tv_cnt3", tv_cnt, 3);

        // NACK once then succeed
        plans.push_back(mk(1'b1, 2'd0, 8'h00, 8'h00, 8'h00));
        plans.push_back(mk(1'b0, 2'd2, 8'h12, 8'h34, 8'h00));
        wait_reqs(6);
        chk("retry_reqs", reqs.size(), 6);
        chk("retry_tv", tv_cnt, 4);
        chk("retry_temp", temp, 16'h1234);
        chk("retry_err", {err, err_cnt}, 0);

        // Persistent NACK exhausts retries
        for (int i = 0; i < 3; i++) plans.push_back(mk(1'b1, 2'd0, 8'h00, 8'h00, 8'h00));
        wait_reqs(9);
        chk("pnack_reqs", reqs.size(), 9);
        chk("pnack_err", err, 1);
        chk("pnack_errcnt", err_cnt, 1);
        chk("pnack_temp", temp, 16'h1234);
        chk("pnack_tv", tv_cnt, 4);
        clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_errcnt", err_cnt, 0);

        // Short read retried
        plans.push_back(mk(1'b0, 2'd1, 8'hAB, 8'h00, 8'h00));
        plans.push_back(mk(1'b0, 2'd2, 8'h56, 8'h78, 8'h00));
        wait_reqs(11);
        chk("short_reqs", reqs.size(), 11);
        chk("short_tv", tv_cnt, 5);
        chk("short_temp", temp, 16'h5678);

        // Randomized polls against the transaction-level model
        exp_req = 11; exp_tv = 5; exp_temp = 16'h5678; exp_err = 1'b0; exp_errcnt = 0;
        for (int p = 0; p < 8; p++) begin
            att = 0; ok = 1'b0;
            while (!ok && att < 3) begin
                o = $urandom_range(0, 4);
                pl = mk(o == 3, (o == 4) ? 2'd1 : (o == 2) ? 2'd3 : 2'd2,
                        8'($urandom), 8'($urandom), 8'($urandom));
                plans.push_back(pl);
                att++;
                if (o < 3) begin
                    ok = 1'b1;
                    exp_temp = {pl.b0, pl.b1};
                end
            end
            exp_req += att;
            if (ok) exp_tv++;
            else begin
                exp_err = 1'b1;
                exp_errcnt++;
            end
            wait_reqs(exp_req);
            chk("rand_reqs", reqs.size(), exp_req);
            chk("rand_tv", tv_cnt, exp_tv);
            chk("rand_temp", temp, exp_temp);
            chk("rand_err", err, exp_err);
            chk("rand_errcnt", err_cnt, exp_errcnt);
        end

        // Enable drop while a read is in flight
        plans.push_back(mk(1'b0, 2'd2, 8'h9A, 8'hBC, 8'h00));
        n = exp_req + 1;
        k = 0;
        while (reqs.size() < n && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (reqs.size() < n) chk("drop_req_timeout", reqs.size(), n);
        enable = 1'b0;
        k = 0;
        while (tv_cnt < exp_tv + 1 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        repeat (300) @(posedge clk); #1;
        chk("drop_tv", tv_cnt, exp_tv + 1);
        chk("drop_temp", temp, 16'h9ABC);
        chk("drop_noreq", reqs.size(), n);
        chk("drop_idle", active, 0);
        chk("tv_single", tv_dbl, 0);

        // Asynchronous reset while a request is pending
        plans.push_back(mk(1'b0, 2'd2, 8'h11, 8'h22, 8'h00));
        enable = 1'b1;
        k = 0;
        while (req !== 1'b1 && k < 400) begin
            @(posedge clk); #1; k++;
        end
        chk("pre_rst_req", req, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_req", req, 0);
        chk("arst_addr", addr, 0);
        chk("arst_len", blen, 0);
        chk("arst_temp", temp, 0);
        chk("arst_flags", {tv, cfg_done, err, active}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
